// File: rtl/ifu_fetch_if.sv
// Fetch-unit port bundle: redirect input, instruction-memory req/ack port
// and the decode-side valid/ready port.
interface ifu_fetch_if;
    logic        Redirect;
    logic [29:0] RedirectPC;
    logic        ImReq;
    logic [29:0] ImAddr;
    logic        ImAck;
    logic [31:0] ImRdata;
    logic        InstrValid;
    logic [31:0] Instr;
    logic [29:0] InstrPC;
    logic        InstrReady;

    // Fetch unit side
    modport master (
        input  Redirect, RedirectPC, ImAck, ImRdata, InstrReady,
        output ImReq, ImAddr, InstrValid, Instr, InstrPC
    );

    // Environment side (NPC logic, instruction memory, decode)
    modport slave (
        output Redirect, RedirectPC, ImAck, ImRdata, InstrReady,
        input  ImReq, ImAddr, InstrValid, Instr, InstrPC
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction-fetch front end. Owns the word-addressed fetch PC, requests
// words from instruction memory and buffers them in a 2-entry FIFO that
// decode drains. A redirect flushes the FIFO and restarts fetch at the new PC.
// All outputs are registered; the next head of the FIFO is computed
// combinationally so a word acked in cycle N is presented in cycle N+1.
module ifu_fetch #(
    parameter logic [29:0] RESET_PC = 30'h0000_0C00,
    parameter int          DEPTH    = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    ifu_fetch_if.master bus
);

    localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_n;
    logic [29:0] pc_r;
    logic [29:0] pc_n;
    logic [1:0]  count_r;
    logic [1:0]  count_n;
    logic        rd_ptr_r;
    logic        rd_ptr_n;
    logic        wr_ptr_r;
    logic        wr_ptr_n;

    logic [31:0] mem_data_r [0:1];
    logic [29:0] mem_pc_r   [0:1];

    logic        im_req_r;
    logic        instr_valid_r;
    logic [31:0] instr_r;
    logic [29:0] instr_pc_r;

    logic        fetch_s;
    logic        pop_s;
    logic        push_s;
    logic [31:0] head_data_s;
    logic [29:0] head_pc_s;

    // Next-state computation: redirect wins over fetch, push and pop.
    always_comb begin
        fetch_s  = im_req_r & bus.ImAck;
        pop_s    = instr_valid_r & bus.InstrReady;
        push_s   = 1'b0;
        pc_n     = pc_r;
        count_n  = count_r;
        rd_ptr_n = rd_ptr_r;
        wr_ptr_n = wr_ptr_r;
        if (bus.Redirect) begin
            // Acked data in this cycle is dropped; a pop still completes.
            pc_n     = bus.RedirectPC;
            count_n  = 2'd0;
            rd_ptr_n = 1'b0;
            wr_ptr_n = 1'b0;
        end else begin
            push_s  = fetch_s;
            count_n = count_r + {1'b0, fetch_s} - {1'b0, pop_s};
            if (fetch_s) begin
                pc_n     = pc_r + 30'd1;
                wr_ptr_n = ~wr_ptr_r;
            end else begin
                pc_n     = pc_r;
                wr_ptr_n = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_n = ~rd_ptr_r;
            end else begin
                rd_ptr_n = rd_ptr_r;
            end
        end
    end

    // Next FIFO head: bypass the word being pushed when it lands at the head.
    always_comb begin
        head_data_s = mem_data_r[rd_ptr_n];
        head_pc_s   = mem_pc_r[rd_ptr_n];
        if (push_s && (wr_ptr_r == rd_ptr_n)) begin
            head_data_s = bus.ImRdata;
            head_pc_s   = pc_r;
        end else begin
            head_data_s = mem_data_r[rd_ptr_n];
            head_pc_s   = mem_pc_r[rd_ptr_n];
        end
    end

    // FSM state mirrors the FIFO occupancy.
    always_comb begin
        state_n = ST_FETCH;
        if (count_n == FULL_COUNT) begin
            state_n = ST_FULL;
        end else begin
            state_n = ST_FETCH;
        end
    end

    // Control FSM, fetch PC, pointers and registered outputs.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r       <= ST_FETCH;
            pc_r          <= RESET_PC;
            count_r       <= 2'd0;
            rd_ptr_r      <= 1'b0;
            wr_ptr_r      <= 1'b0;
            im_req_r      <= 1'b0;
            instr_valid_r <= 1'b0;
            instr_r       <= 32'd0;
            instr_pc_r    <= 30'd0;
        end else begin
            state_r  <= state_n;
            pc_r     <= pc_n;
            count_r  <= count_n;
            rd_ptr_r <= rd_ptr_n;
            wr_ptr_r <= wr_ptr_n;
            case (state_n)
                ST_FETCH: im_req_r <= 1'b1;
                ST_FULL:  im_req_r <= 1'b0;
                default:  im_req_r <= 1'b0;
            endcase
            instr_valid_r <= (count_n != 2'd0);
            if (count_n != 2'd0) begin
                instr_r    <= head_data_s;
                instr_pc_r <= head_pc_s;
            end else begin
                instr_r    <= instr_r;
                instr_pc_r <= instr_pc_r;
            end
        end
    end

    // FIFO storage written on each accepted, non-flushed fetch.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 2; i++) begin
                mem_data_r[i] <= 32'd0;
                mem_pc_r[i]   <= 30'd0;
            end
        end else begin
            if (push_s) begin
                mem_data_r[wr_ptr_r] <= bus.ImRdata;
                mem_pc_r[wr_ptr_r]   <= pc_r;
            end else begin
                mem_data_r[wr_ptr_r] <= mem_data_r[wr_ptr_r];
                mem_pc_r[wr_ptr_r]   <= mem_pc_r[wr_ptr_r];
            end
        end
    end

    assign bus.ImReq      = im_req_r;
    assign bus.ImAddr     = pc_r;
    assign bus.InstrValid = instr_valid_r;
    assign bus.Instr      = instr_r;
    assign bus.InstrPC    = instr_pc_r;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios followed by random
// traffic, all compared cycle by cycle against a queue-based reference model.
`timescale 1ns/1ps
module tb_ifu_fetch;

    typedef struct {
        logic [31:0] data;
        logic [29:0] pc;
    } ent_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    // reference model state
    ent_t        q[$];
    logic [29:0] pc_m;
    logic        req_m;

    ifu_fetch_if bus ();

    ifu_fetch dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        pc_m  = 30'h0000_0C00;
        req_m = 1'b0;
    endtask

    task automatic model_step(input logic rd, input logic [29:0] rpc, input logic ack,
                              input logic [31:0] dat, input logic rdy);
        logic fetch;
        logic pop;
        ent_t e;
        fetch = req_m & ack;
        pop   = (q.size() > 0) & rdy;
        if (rd) begin
            q.delete();
            pc_m = rpc;
        end else begin
            if (pop) void'(q.pop_front());
            if (fetch) begin
                e.data = dat;
                e.pc   = pc_m;
                q.push_back(e);
                pc_m = pc_m + 30'd1;
            end
        end
        req_m = (q.size() < 2);
    endtask

    task automatic check_model();
        chk("im_req", {63'd0, bus.ImReq}, {63'd0, req_m});
        chk("im_addr", {34'd0, bus.ImAddr}, {34'd0, pc_m});
        chk("instr_valid", {63'd0, bus.InstrValid}, {63'd0, (q.size() > 0)});
        if (q.size() > 0) begin
            chk("instr", {32'd0, bus.Instr}, {32'd0, q[0].data});
            chk("instr_pc", {34'd0, bus.InstrPC}, {34'd0, q[0].pc});
        end
    endtask

    // Called at a negedge: check, drive, step model on posedge, return at negedge.
    task automatic cyc(input logic rd, input logic [29:0] rpc, input logic ack,
                       input logic [31:0] dat, input logic rdy);
        check_model();
        bus.Redirect   = rd;
        bus.RedirectPC = rpc;
        bus.ImAck      = ack;
        bus.ImRdata    = dat;
        bus.InstrReady = rdy;
        @(posedge clk);
        model_step(rd, rpc, ack, dat, rdy);
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_im_req", {63'd0, bus.ImReq}, 64'd0);
        chk("rst_im_addr", {34'd0, bus.ImAddr}, 64'h0C00);
        chk("rst_valid", {63'd0, bus.InstrValid}, 64'd0);
        chk("rst_instr", {32'd0, bus.Instr}, 64'd0);
        chk("rst_instr_pc", {34'd0, bus.InstrPC}, 64'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        bus.Redirect   = 1'b0;
        bus.RedirectPC = 30'd0;
        bus.ImAck      = 1'b0;
        bus.ImRdata    = 32'd0;
        bus.InstrReady = 1'b0;
        model_reset();
        #12;
        chk_reset_outputs();
        @(negedge clk);
        rst = 1'b1;

        // 1: streaming with ack and ready high
        for (int i = 0; i < 5; i++) cyc(1'b0, 30'd0, 1'b1, 32'hA000_0000 + 32'(i), 1'b1);

        // 2: decode stalls, FIFO fills, single pop
        for (int i = 0; i < 4; i++) cyc(1'b0, 30'd0, 1'b1, 32'hB000_0000 + 32'(i), 1'b0);
        chk("full_no_req", {63'd0, bus.ImReq}, 64'd0);
        cyc(1'b0, 30'd0, 1'b1, 32'hB100_0000, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 30'd0, 1'b1, 32'hB200_0000 + 32'(i), 1'b1);

        // 3: request held without ack
        for (int i = 0; i < 3; i++) cyc(1'b0, 30'd0, 1'b0, 32'hDEAD_0000, 1'b1);
        cyc(1'b0, 30'd0, 1'b1, 32'hC000_0001, 1'b1);
        cyc(1'b0, 30'd0, 1'b0, 32'd0, 1'b1);

        // 4: redirect in the same cycle as an ack
        cyc(1'b1, 30'h0000_0C40, 1'b1, 32'hBAD0_BAD0, 1'b1);
        chk("redir_addr", {34'd0, bus.ImAddr}, 64'h0C40);
        chk("redir_valid", {63'd0, bus.InstrValid}, 64'd0);
        cyc(1'b0, 30'd0, 1'b1, 32'hD000_0040, 1'b0);
        chk("redir_first_pc", {34'd0, bus.InstrPC}, 64'h0C40);
        cyc(1'b0, 30'd0, 1'b1, 32'hD000_0041, 1'b0);

        // redirect while full
        cyc(1'b1, 30'h0000_1234, 1'b0, 32'd0, 1'b0);
        chk("redir_full_req", {63'd0, bus.ImReq}, 64'd1);

        // 5: PC wrap
        cyc(1'b1, 30'h3FFF_FFFF, 1'b0, 32'd0, 1'b1);
        chk("wrap_addr_hi", {34'd0, bus.ImAddr}, 64'h3FFF_FFFF);
        cyc(1'b0, 30'd0, 1'b1, 32'hE000_0001, 1'b1);
        chk("wrap_addr_lo", {34'd0, bus.ImAddr}, 64'd0);
        cyc(1'b0, 30'd0, 1'b1, 32'hE000_0002, 1'b1);

        // 6: async reset mid-stream with FIFO full
        for (int i = 0; i < 3; i++) cyc(1'b0, 30'd0, 1'b1, 32'hF000_0000 + 32'(i), 1'b0);
        check_model();
        bus.ImAck = 1'b1;
        rst = 1'b0;
        #1;
        chk_reset_outputs();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk_reset_outputs();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b0, 30'd0, 1'b1, 32'h1234_0000 + 32'(i), 1'b1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic        rd;
            logic [29:0] rpc;
            rd  = ($urandom_range(0, 15) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? 30'h3FFF_FFFE : 30'($urandom);
            cyc(rd, rpc, 1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 2) != 0));
        end
        check_model();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
